// File: rtl/simon_pkg.sv
//==============================================================================
// Package : simon_pkg
// Desc    : Shared defaults and button types for the simon input stage and core.
// Rev     : 1.0
//==============================================================================
`default_nettype none

package simon_pkg;

    localparam int NUM_BTN_DEF  = 4;
    localparam int DEBOUNCE_DEF = 50000;

    typedef logic [1:0] btn_idx_t;

    typedef enum logic [1:0] {
        BTN_GREEN  = 2'd0,
        BTN_RED    = 2'd1,
        BTN_YELLOW = 2'd2,
        BTN_BLUE   = 2'd3
    } btn_e;

endpackage

`default_nettype wire

// File: rtl/simon_debounce_chan.sv
//==============================================================================
// Module : simon_debounce_chan
// Desc   : One button: 2-flop synchroniser, counter debounce, stable-change strobe.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module simon_debounce_chan
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic btn_raw,
    output logic level,
    output logic toggle
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_flip;

    assign w_flip = (r_sync != r_stable) && (r_cnt == c_CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (ena) begin
            r_meta <= btn_raw;
            r_sync <= r_meta;
            if (r_sync == r_stable) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_stable <= r_sync;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Strobe fires in the cycle the stable value is about to change; level is still the old value.
    assign level  = r_stable;
    assign toggle = w_flip & ena;

endmodule

`default_nettype wire

// File: rtl/simon_button_conditioner.sv
//==============================================================================
// Module : simon_button_conditioner
// Desc   : Debounced button events to the simon core over a valid/ack handshake.
//          Define RELEASE_EVT_EN to also deliver release events.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module simon_button_conditioner
    import simon_pkg::*;
#(
    parameter int NUM_BTN         = NUM_BTN_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int IDX_W           = $clog2(NUM_BTN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic               press_valid,
    output logic [IDX_W-1:0]   press_idx,
    output logic               press_rel,
    input  logic               press_ack,
    output logic [NUM_BTN-1:0] btn_level,
    output logic               overrun
);

    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_toggle;
    logic [NUM_BTN-1:0] w_rise;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
            simon_debounce_chan #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_chan (
                .clk    (clk),
                .rst_n  (rst_n),
                .ena    (ena),
                .btn_raw(btn_raw[gi]),
                .level  (w_level[gi]),
                .toggle (w_toggle[gi])
            );
        end
    endgenerate

    assign w_rise = w_toggle & ~w_level;

    logic [NUM_BTN-1:0] r_press_pend;
    logic [NUM_BTN-1:0] w_press_clr;
    logic [NUM_BTN-1:0] w_sel_oh;
    logic [IDX_W-1:0]   w_sel_idx;
    logic [IDX_W-1:0]   r_idx;
    logic               w_sel_rel;
    logic               w_any;
    logic               w_load;
    logic               w_lost;
    logic               r_valid;
    logic               r_overrun;

`ifdef RELEASE_EVT_EN
    logic [NUM_BTN-1:0] r_rel_pend;
    logic [NUM_BTN-1:0] w_fall;
    logic [NUM_BTN-1:0] w_rel_clr;
    logic               r_rel;

    assign w_fall    = w_toggle & w_level;
    assign w_any     = (|r_press_pend) | (|r_rel_pend);
    assign w_rel_clr = (w_load && w_sel_rel) ? w_sel_oh : '0;
    assign w_lost    = (|(r_press_pend & w_rise)) | (|(r_rel_pend & w_fall));
    assign press_rel = r_rel;
`else
    assign w_any     = |r_press_pend;
    assign w_lost    = |(r_press_pend & w_rise);
    assign press_rel = 1'b0;
`endif

    // Descending scans leave the lowest set index; presses are scanned last so they win.
    always_comb begin
        w_sel_idx = '0;
        w_sel_rel = 1'b0;
`ifdef RELEASE_EVT_EN
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (r_rel_pend[i]) begin
                w_sel_idx = IDX_W'(i);
                w_sel_rel = 1'b1;
            end
        end
`endif
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (r_press_pend[i]) begin
                w_sel_idx = IDX_W'(i);
                w_sel_rel = 1'b0;
            end
        end
    end

    assign w_load      = (~r_valid | press_ack) & w_any;
    assign w_sel_oh    = NUM_BTN'(1) << w_sel_idx;
    assign w_press_clr = (w_load && !w_sel_rel) ? w_sel_oh : '0;

    // Set after clear: an edge arriving as its button is loaded stays pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_press_pend <= '0;
            r_valid      <= 1'b0;
            r_idx        <= '0;
            r_overrun    <= 1'b0;
`ifdef RELEASE_EVT_EN
            r_rel_pend   <= '0;
            r_rel        <= 1'b0;
`endif
        end else if (ena) begin
            r_press_pend <= (r_press_pend & ~w_press_clr) | w_rise;
            r_overrun    <= r_overrun | w_lost;
`ifdef RELEASE_EVT_EN
            r_rel_pend   <= (r_rel_pend & ~w_rel_clr) | w_fall;
`endif
            if (w_load) begin
                r_valid <= 1'b1;
                r_idx   <= w_sel_idx;
`ifdef RELEASE_EVT_EN
                r_rel   <= w_sel_rel;
`endif
            end else if (press_ack) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign press_valid = r_valid;
    assign press_idx   = r_idx;
    assign btn_level   = w_level;
    assign overrun     = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_simon_button_conditioner.sv
//==============================================================================
// Module : tb_simon_button_conditioner
// Desc   : Directed stimulus with an event scoreboard for the button conditioner.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_simon_button_conditioner;
    import simon_pkg::*;

    localparam int DC = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [3:0] btn_raw;
    logic       press_valid;
    logic [1:0] press_idx;
    logic       press_rel;
    logic       press_ack;
    logic [3:0] btn_level;
    logic       overrun;

    simon_button_conditioner #(
        .NUM_BTN        (4),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .btn_raw    (btn_raw),
        .press_valid(press_valid),
        .press_idx  (press_idx),
        .press_rel  (press_rel),
        .press_ack  (press_ack),
        .btn_level  (btn_level),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] idx;
        logic       rel;
    } evt_t;

    evt_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    bit   rel_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input bit rel);
        evt_t e;
        e.idx = 2'(idx);
        e.rel = rel;
        exp_q.push_back(e);
    endtask

    // Monitor: an event is consumed on the edge following a sample with valid, ack and ena high.
    always @(negedge clk) begin
        if (press_rel === 1'b1) rel_seen = 1'b1;
        if (rst_n && ena && press_valid && press_ack) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_event: got idx=%0d rel=%0d expected none", press_idx, press_rel);
            end else begin
                evt_t e;
                e = exp_q.pop_front();
                chk("event{idx,rel}", {29'd0, press_idx, press_rel}, {29'd0, e.idx, e.rel});
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit bad;
        rst_n     = 1'b0;
        ena       = 1'b1;
        press_ack = 1'b0;
        btn_raw   = 4'hF;

        // Reset with all buttons held
        step(3);
        chk("rst_valid", 32'(press_valid), 32'd0);
        chk("rst_idx", 32'(press_idx), 32'd0);
        chk("rst_rel", 32'(press_rel), 32'd0);
        chk("rst_level", 32'(btn_level), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        rst_n     = 1'b1;
        press_ack = 1'b1;
        for (int i = 0; i < 4; i++) push(i, 1'b0);
        step(DC + 1);
        chk("rst_level_pre", 32'(btn_level), 32'h0);
        step(1);
        chk("rst_level_post", 32'(btn_level), 32'hF);
        chk("rst_valid_pend", 32'(press_valid), 32'd0);
        step(1);
        chk("rst_first_evt", {30'd0, press_valid, press_idx == 2'd0}, 32'd3);
        btn_raw = 4'h0;
`ifdef RELEASE_EVT_EN
        for (int i = 0; i < 4; i++) push(i, 1'b1);
`endif
        step(20);
        chk("rst_released", 32'(btn_level), 32'h0);

        // Glitch of DC-1 cycles is rejected
        bad = 1'b0;
        btn_raw[int'(BTN_YELLOW)] = 1'b1;
        for (int k = 0; k < 27; k++) begin
            if (k == DC - 1) btn_raw = 4'h0;
            step(1);
            if (btn_level != 4'h0 || press_valid) bad = 1'b1;
        end
        chk("glitch_ignored", 32'(bad), 32'd0);

        // DC+1 cycle pulse is accepted
        btn_raw[int'(BTN_YELLOW)] = 1'b1;
        push(int'(BTN_YELLOW), 1'b0);
        step(DC + 1);
        btn_raw = 4'h0;
        step(1);
        chk("pulse_level", 32'(btn_level), 32'h4);
        chk("pulse_valid_pre", 32'(press_valid), 32'd0);
        step(1);
        chk("pulse_valid", 32'(press_valid), 32'd1);
        chk("pulse_idx", 32'(press_idx), 32'd2);
`ifdef RELEASE_EVT_EN
        push(int'(BTN_YELLOW), 1'b1);
`endif
        step(15);

        // Simultaneous presses on buttons 1 and 3
        btn_raw = 4'b1010;
        push(1, 1'b0);
        push(3, 1'b0);
        step(DC + 2);
        chk("simul_level", 32'(btn_level), 32'hA);
        step(1);
        chk("simul_first", {30'd0, press_valid, press_idx == 2'd1}, 32'd3);
        step(1);
        chk("simul_second", {30'd0, press_valid, press_idx == 2'd3}, 32'd3);
        step(1);
        chk("simul_drop", 32'(press_valid), 32'd0);
        chk("simul_overrun", 32'(overrun), 32'd0);
        btn_raw = 4'h0;
`ifdef RELEASE_EVT_EN
        push(1, 1'b1);
        push(3, 1'b1);
`endif
        step(16);

        // Overrun: three presses of button 0 with no ack
        press_ack = 1'b0;
        btn_raw   = 4'b0001;
        push(0, 1'b0);
        step(DC + 3);
        chk("ovr_held", {30'd0, press_valid, press_idx == 2'd0}, 32'd3);
        btn_raw = 4'h0;
        step(12);
        btn_raw = 4'b0001;
        push(0, 1'b0);
        step(12);
        chk("ovr_second_no_ovr", 32'(overrun), 32'd0);
        btn_raw = 4'h0;
        step(12);
        btn_raw = 4'b0001;
        step(12);
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_idx_held", {30'd0, press_valid, press_idx == 2'd0}, 32'd3);
`ifdef RELEASE_EVT_EN
        push(0, 1'b1);
`endif
        press_ack = 1'b1;
        step(5);
        chk("ovr_drained", 32'(press_valid), 32'd0);
        btn_raw = 4'h0;
`ifdef RELEASE_EVT_EN
        push(0, 1'b1);
`endif
        step(14);
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // ena freeze mid-debounce, then ack ignored while frozen
        press_ack = 1'b0;
        btn_raw   = 4'b1000;
        push(3, 1'b0);
        step(4);
        ena = 1'b0;
        step(5);
        chk("ena_frozen_level", 32'(btn_level), 32'h0);
        ena = 1'b1;
        step(DC + 2 - 5);
        chk("ena_level_pre", 32'(btn_level), 32'h0);
        step(1);
        chk("ena_level_post", 32'(btn_level), 32'h8);
        step(1);
        chk("ena_evt", {30'd0, press_valid, press_idx == 2'd3}, 32'd3);
        ena       = 1'b0;
        press_ack = 1'b1;
        step(3);
        chk("ena_ack_ignored", 32'(press_valid), 32'd1);
        ena = 1'b1;
        step(1);
        chk("ena_ack_taken", 32'(press_valid), 32'd0);
        btn_raw = 4'h0;
`ifdef RELEASE_EVT_EN
        push(3, 1'b1);
`endif
        step(14);

        // Reset in the middle of a handshake discards the held event
        press_ack = 1'b0;
        btn_raw   = 4'b0001;
        step(DC + 3);
        chk("mid_rst_held", 32'(press_valid), 32'd1);
        rst_n   = 1'b0;
        btn_raw = 4'h0;
        step(1);
        chk("mid_rst_valid", 32'(press_valid), 32'd0);
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        chk("mid_rst_level", 32'(btn_level), 32'h0);
        rst_n = 1'b1;
        step(14);
        chk("mid_rst_quiet", 32'(press_valid), 32'd0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
`ifndef RELEASE_EVT_EN
        chk("rel_const_zero", 32'(rel_seen), 32'd0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
